wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single 64-bit register-file write port between two requesters: the in-order pipeline write-back stage and a long-latency unit (multi-cycle mul/div, uncached load return).
- The pipeline has priority. Long-latency results wait in a small side FIFO and drain into idle write slots.
- A starvation counter forces a one-cycle pipeline stall so that buffered results are always written.
- Sits between the write-back stage and the register file.

Parameters:
- DEPTH, 2, side-FIFO entries (power of two, >=2)
- STARVE_MAX, 4, consecutive cycles the FIFO head may lose arbitration before a pipeline stall is forced (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pipe_i_rd  in  5  write-back destination register
- pipe_i_data  in  64  write-back data
- pipe_i_wen  in  1  write-back write request
- lu_i_valid  in  1  long-latency result valid
- lu_i_rd  in  5  long-latency destination register
- lu_i_data  in  64  long-latency result data
- lu_o_ready  out  1  side FIFO can accept; equals !full
- arb_o_rd  out  5  register-file write address (registered)
- arb_o_data  out  64  register-file write data (registered)
- arb_o_wen  out  1  register-file write enable (registered)
- arb_o_pipe_stall  out  1  combinational; pipeline must hold pipe_i_* stable and re-present them next cycle
- arb_o_pending  out  1  FIFO holds at least one valid entry (registered state)

Behaviour:
- Reset (async, rst_n low): arb_o_* all 0; FIFO empty (pointers 0, all entry valid bits 0); starvation counter 0. Consequently lu_o_ready=1, arb_o_pending=0 and arb_o_pipe_stall=0.
- The clock is ignored while rst_n is low. An operation in flight is lost, and the FIFO contents are discarded.
- Effective pipe request: preq = pipe_i_wen && (pipe_i_rd != 0). x0 writes are never forwarded.
- LU push: on lu_i_valid && lu_o_ready, the entry {rd, data, valid = (lu_i_rd != 0)} is written at the tail.
  - A pushed entry is not eligible for grant until the next cycle (no bypass).
  - lu_o_ready does not consider a same-cycle pop. Full means no accept, even if the FIFO is popping.
- Grant decision, evaluated every cycle:
  - stall = FIFO non-empty && cnt == STARVE_MAX.
  - If stall: the FIFO head is granted, and the pipe request is ignored this cycle.
  - Else if preq: the pipe is granted.
  - Else if the FIFO is non-empty: the FIFO head is granted.
  - Else: no grant.
- Output register: one-cycle latency. The granted {rd, data} is registered to arb_o_rd/arb_o_data.
  - arb_o_wen=1 only for a pipe grant, or a FIFO grant whose head is valid.
  - A FIFO grant of an invalid (squashed) head pops with arb_o_wen=0.
  - With no grant, arb_o_wen=0 and rd/data hold their previous values.
- Starvation counter:
  - Increments when the FIFO is non-empty and the pipe wins. Saturates at STARVE_MAX.
  - Clears on any FIFO grant, and whenever the FIFO is empty.
- WAW squash: when the pipe is granted, every FIFO entry with valid=1 and rd == pipe_i_rd has its valid bit cleared in the same edge.
  - The pipe write is program-order younger, so the older buffered value must not overwrite it.
  - An entry pushed in the same cycle with a matching rd is not squashed.
- Pointer wrap-around: pointers are log2(DEPTH)+1 bits wide. Full is detected when the MSBs differ and the lower bits are equal. Empty is detected when the pointers are equal.
- Simultaneous push and pop on a non-full FIFO both take effect, and the occupancy is unchanged.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- When defined:
  - Adds outputs arb_o_stall_cnt[31:0] and arb_o_squash_cnt[31:0].
  - arb_o_stall_cnt counts cycles with arb_o_pipe_stall=1.
  - arb_o_squash_cnt counts FIFO entries invalidated by WAW squash.
  - Both counters wrap modulo 2^32 and reset to 0.
- When undefined: these ports and their registers do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset, then pipe write rd=3 data=0xAA -> next cycle arb_o_wen=1, rd=3, data=0xAA. A pipe write to rd=0 -> arb_o_wen=0.
- Pipe idle; LU push rd=7 data=0x1234 -> the LU push itself causes no write in its push cycle. arb_o_wen=1, rd=7 appears 2 cycles after the push, and arb_o_pending then drops.
- DEPTH=2: push 2 LU results while the pipe writes every cycle -> lu_o_ready=0 after the second push. arb_o_pipe_stall=1 after 4 pipe-won cycles, then the head drains, rd/data match the push order, and the counter clears.
- LU push rd=5 data=1, then a pipe write rd=5 data=2 while the entry is buffered -> the register file sees only rd=5 data=2. The squashed pop produces arb_o_wen=0.
- Assert rst_n low mid-drain with 2 entries buffered -> arb_o_wen=0, arb_o_pending=0 and lu_o_ready=1 immediately, with no clock edge needed.
- With WB_ARB_PERF_EN: repeat the starvation and squash scenarios -> arb_o_stall_cnt=1, arb_o_squash_cnt=1.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port arbitration bus.
// Carries the write-back request, the long-latency result handshake and the
// arbitrated register-file write. With WB_ARB_PERF_EN defined it also carries
// the stall and squash performance counters.
interface wb_port_arbiter_if;
  logic [4:0]  pipe_i_rd;
  logic [63:0] pipe_i_data;
  logic        pipe_i_wen;
  logic        lu_i_valid;
  logic [4:0]  lu_i_rd;
  logic [63:0] lu_i_data;
  logic        lu_o_ready;
  logic [4:0]  arb_o_rd;
  logic [63:0] arb_o_data;
  logic        arb_o_wen;
  logic        arb_o_pipe_stall;
  logic        arb_o_pending;
`ifdef WB_ARB_PERF_EN
  logic [31:0] arb_o_stall_cnt;
  logic [31:0] arb_o_squash_cnt;
`endif

  // Arbiter side
  modport slave (
    input  pipe_i_rd, pipe_i_data, pipe_i_wen,
    input  lu_i_valid, lu_i_rd, lu_i_data,
    output lu_o_ready,
    output arb_o_rd, arb_o_data, arb_o_wen, arb_o_pipe_stall, arb_o_pending
`ifdef WB_ARB_PERF_EN
    , output arb_o_stall_cnt, arb_o_squash_cnt
`endif
  );

  // Requester / register-file side
  modport master (
    output pipe_i_rd, pipe_i_data, pipe_i_wen,
    output lu_i_valid, lu_i_rd, lu_i_data,
    input  lu_o_ready,
    input  arb_o_rd, arb_o_data, arb_o_wen, arb_o_pipe_stall, arb_o_pending
`ifdef WB_ARB_PERF_EN
    , input arb_o_stall_cnt, arb_o_squash_cnt
`endif
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// in-order write-back stage (priority) and a long-latency unit whose results
// wait in a small side FIFO. A starvation counter forces a one-cycle pipeline
// stall so buffered results always drain. A pipe write squashes older buffered
// results to the same register (WAW).
// Optional macro WB_ARB_PERF_EN adds 32-bit stall and squash counters.
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst_n,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  // FIFO storage: rd/data carry no reset, only the valid bits do
  logic [4:0]       ent_rd_q   [DEPTH];
  logic [63:0]      ent_data_q [DEPTH];
  logic [DEPTH-1:0] ent_vld_q, ent_vld_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [4:0]  arb_rd_q, arb_rd_d;
  logic [63:0] arb_data_q, arb_data_d;
  logic        arb_wen_q, arb_wen_d;

  logic [AW-1:0]    head_idx, tail_idx;
  logic             empty, full, preq, stall, push;
  logic             pipe_gnt, fifo_gnt;
  logic [DEPTH-1:0] squash;

  assign head_idx = rd_ptr_q[AW-1:0];
  assign tail_idx = wr_ptr_q[AW-1:0];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign preq     = bus.pipe_i_wen && (bus.pipe_i_rd != 5'd0);
  assign stall    = !empty && (cnt_q == CNT_MAX);
  assign push     = bus.lu_i_valid && !full;
  assign pipe_gnt = !stall && preq;
  assign fifo_gnt = !empty && (stall || !preq);

  assign bus.lu_o_ready       = !full;
  assign bus.arb_o_pipe_stall = stall;
  assign bus.arb_o_pending    = !empty;
  assign bus.arb_o_rd         = arb_rd_q;
  assign bus.arb_o_data       = arb_data_q;
  assign bus.arb_o_wen        = arb_wen_q;

  // WAW squash: a granted pipe write kills every older live entry to the same rd
  always_comb begin
    squash = '0;
    if (pipe_gnt) begin
      for (int i = 0; i < DEPTH; i++) begin
        squash[i] = ent_vld_q[i] && (ent_rd_q[i] == bus.pipe_i_rd);
      end
    end
  end

  // Next state for pointers, valid bits, starvation counter and output register
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ent_vld_d  = ent_vld_q & ~squash;
    cnt_d      = cnt_q;
    arb_rd_d   = arb_rd_q;
    arb_data_d = arb_data_q;
    arb_wen_d  = 1'b0;

    if (pipe_gnt) begin
      arb_rd_d   = bus.pipe_i_rd;
      arb_data_d = bus.pipe_i_data;
      arb_wen_d  = 1'b1;
    end else if (fifo_gnt) begin
      arb_rd_d   = ent_rd_q[head_idx];
      arb_data_d = ent_data_q[head_idx];
      arb_wen_d  = ent_vld_q[head_idx];
    end

    // Popped slots drop their valid bit so only live entries can match a squash
    if (fifo_gnt) begin
      ent_vld_d[head_idx] = 1'b0;
      rd_ptr_d            = rd_ptr_q + PW'(1);
    end

    // The tail slot is never live, so a same-cycle push is not squashed
    if (push) begin
      ent_vld_d[tail_idx] = (bus.lu_i_rd != 5'd0);
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end

    if (empty || fifo_gnt) begin
      cnt_d = '0;
    end else if (pipe_gnt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Control state and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ent_vld_q  <= '0;
      cnt_q      <= '0;
      arb_rd_q   <= '0;
      arb_data_q <= '0;
      arb_wen_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ent_vld_q  <= ent_vld_d;
      cnt_q      <= cnt_d;
      arb_rd_q   <= arb_rd_d;
      arb_data_q <= arb_data_d;
      arb_wen_q  <= arb_wen_d;
    end
  end

  // FIFO payload write at the tail
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[tail_idx]   <= bus.lu_i_rd;
      ent_data_q[tail_idx] <= bus.lu_i_data;
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] squash_cnt_q, squash_cnt_d;

  assign bus.arb_o_stall_cnt  = stall_cnt_q;
  assign bus.arb_o_squash_cnt = squash_cnt_q;

  // Counter increments: one per stall cycle, one per squashed entry
  always_comb begin
    stall_cnt_d  = stall_cnt_q + 32'(stall);
    squash_cnt_d = squash_cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      squash_cnt_d = squash_cnt_d + 32'(squash[i]);
    end
  end

  // Performance counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed vector table, async reset mid-drain,
// then randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit pw, input logic [4:0] prd, input logic [63:0] pd,
                       input bit lv, input logic [4:0] lrd, input logic [63:0] ld);
    bus.pipe_i_wen  = pw;
    bus.pipe_i_rd   = prd;
    bus.pipe_i_data = pd;
    bus.lu_i_valid  = lv;
    bus.lu_i_rd     = lrd;
    bus.lu_i_data   = ld;
  endtask

  // Directed vectors: inputs, pre-edge {ready, stall, pending}, post-edge {wen, rd, data}
  typedef struct {
    bit          pw;  logic [4:0] prd; logic [63:0] pd;
    bit          lv;  logic [4:0] lrd; logic [63:0] ld;
    bit          rdy; bit stl; bit pend;
    bit          wen; logic [4:0] rd;  logic [63:0] data;
  } vec_t;
  localparam int NV = 18;
  vec_t tbl [NV];

  // Reference model: FIFO as a queue of {rd, data, valid}
  typedef struct {logic [4:0] rd; logic [63:0] data; bit v;} ent_t;
  ent_t        mq[$];
  int          m_starve;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  bit          m_wen;
  int          m_stalls;
  int          m_squashes;

  task automatic model_reset();
    mq.delete();
    m_starve = 0; m_rd = '0; m_data = '0; m_wen = 1'b0;
    m_stalls = 0; m_squashes = 0;
  endtask

  task automatic model_step(input bit pw, input logic [4:0] prd, input logic [63:0] pd,
                            input bit lv, input logic [4:0] lrd, input logic [63:0] ld);
    bit   preq;
    bit   stl;
    bit   push;
    int   n;
    ent_t e;
    preq = pw && (prd != 5'd0);
    n    = mq.size();
    stl  = (n > 0) && (m_starve == STARVE_MAX);
    push = lv && (n < DEPTH);
    if (stl) m_stalls++;
    if (stl || (!preq && n > 0)) begin
      e = mq.pop_front();
      m_rd = e.rd; m_data = e.data; m_wen = e.v;
      m_starve = 0;
    end else if (preq) begin
      m_rd = prd; m_data = pd; m_wen = 1'b1;
      foreach (mq[i]) begin
        if (mq[i].v && mq[i].rd == prd) begin
          mq[i].v = 1'b0;
          m_squashes++;
        end
      end
      if (n > 0 && m_starve < STARVE_MAX) m_starve++;
    end else begin
      m_wen = 1'b0;
    end
    if (n == 0) m_starve = 0;
    if (push) mq.push_back('{lrd, ld, lrd != 5'd0});
  endtask

  initial begin
    bit          pw, lv, held, m_stl;
    logic [4:0]  prd, lrd;
    logic [63:0] pd, ld;

    // pipe rd3, pipe to x0, LU single drain
    tbl[0]  = '{1, 5'd3, 64'hAA,   0, 5'd0,  64'h0,    1, 0, 0,  1, 5'd3, 64'hAA};
    tbl[1]  = '{1, 5'd0, 64'h55,   0, 5'd0,  64'h0,    1, 0, 0,  0, 5'd3, 64'hAA};
    tbl[2]  = '{0, 5'd0, 64'h0,    1, 5'd7,  64'h1234, 1, 0, 0,  0, 5'd3, 64'hAA};
    tbl[3]  = '{0, 5'd0, 64'h0,    0, 5'd0,  64'h0,    1, 0, 1,  1, 5'd7, 64'h1234};
    tbl[4]  = '{0, 5'd0, 64'h0,    0, 5'd0,  64'h0,    1, 0, 0,  0, 5'd7, 64'h1234};
    // starvation: pipe every cycle, two LU pushes, forced stall on the 5th cycle
    tbl[5]  = '{1, 5'd1, 64'h10,   1, 5'd8,  64'h80,   1, 0, 0,  1, 5'd1, 64'h10};
    tbl[6]  = '{1, 5'd2, 64'h20,   1, 5'd9,  64'h90,   1, 0, 1,  1, 5'd2, 64'h20};
    tbl[7]  = '{1, 5'd3, 64'h30,   0, 5'd0,  64'h0,    0, 0, 1,  1, 5'd3, 64'h30};
    tbl[8]  = '{1, 5'd4, 64'h40,   0, 5'd0,  64'h0,    0, 0, 1,  1, 5'd4, 64'h40};
    tbl[9]  = '{1, 5'd5, 64'h50,   0, 5'd0,  64'h0,    0, 0, 1,  1, 5'd5, 64'h50};
    tbl[10] = '{1, 5'd6, 64'h60,   0, 5'd0,  64'h0,    0, 1, 1,  1, 5'd8, 64'h80};
    tbl[11] = '{1, 5'd6, 64'h60,   0, 5'd0,  64'h0,    1, 0, 1,  1, 5'd6, 64'h60};
    tbl[12] = '{0, 5'd0, 64'h0,    0, 5'd0,  64'h0,    1, 0, 1,  1, 5'd9, 64'h90};
    tbl[13] = '{0, 5'd0, 64'h0,    0, 5'd0,  64'h0,    1, 0, 0,  0, 5'd9, 64'h90};
    // WAW squash: buffered rd5=1 overtaken by pipe rd5=2
    tbl[14] = '{0, 5'd0, 64'h0,    1, 5'd5,  64'h1,    1, 0, 0,  0, 5'd9, 64'h90};
    tbl[15] = '{1, 5'd5, 64'h2,    0, 5'd0,  64'h0,    1, 0, 1,  1, 5'd5, 64'h2};
    tbl[16] = '{0, 5'd0, 64'h0,    0, 5'd0,  64'h0,    1, 0, 1,  0, 5'd5, 64'h1};
    tbl[17] = '{0, 5'd0, 64'h0,    0, 5'd0,  64'h0,    1, 0, 0,  0, 5'd5, 64'h1};

    // Reset state
    rst_n = 1'b0;
    drive(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst wen",     64'(bus.arb_o_wen),        64'd0);
    chk("rst rd",      64'(bus.arb_o_rd),         64'd0);
    chk("rst data",    bus.arb_o_data,            64'd0);
    chk("rst ready",   64'(bus.lu_o_ready),       64'd1);
    chk("rst stall",   64'(bus.arb_o_pipe_stall), 64'd0);
    chk("rst pending", 64'(bus.arb_o_pending),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].pw, tbl[i].prd, tbl[i].pd, tbl[i].lv, tbl[i].lrd, tbl[i].ld);
      #2;
      chk($sformatf("v%0d ready", i),   64'(bus.lu_o_ready),       64'(tbl[i].rdy));
      chk($sformatf("v%0d stall", i),   64'(bus.arb_o_pipe_stall), 64'(tbl[i].stl));
      chk($sformatf("v%0d pending", i), 64'(bus.arb_o_pending),    64'(tbl[i].pend));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d wen", i),  64'(bus.arb_o_wen), 64'(tbl[i].wen));
      chk($sformatf("v%0d rd", i),   64'(bus.arb_o_rd),  64'(tbl[i].rd));
      chk($sformatf("v%0d data", i), bus.arb_o_data,     tbl[i].data);
    end
`ifdef WB_ARB_PERF_EN
    chk("perf stall_cnt",  64'(bus.arb_o_stall_cnt),  64'd1);
    chk("perf squash_cnt", 64'(bus.arb_o_squash_cnt), 64'd1);
`endif

    // Async reset with two entries buffered
    drive(1, 5'd1, 64'h11, 1, 5'd10, 64'hA0);
    @(posedge clk);
    #1;
    drive(1, 5'd2, 64'h22, 1, 5'd11, 64'hB0);
    @(posedge clk);
    #1;
    drive(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    chk("pre-rst pending", 64'(bus.arb_o_pending), 64'd1);
    chk("pre-rst ready",   64'(bus.lu_o_ready),    64'd0);
    chk("pre-rst wen",     64'(bus.arb_o_wen),     64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async wen",     64'(bus.arb_o_wen),        64'd0);
    chk("async pending", 64'(bus.arb_o_pending),    64'd0);
    chk("async ready",   64'(bus.lu_o_ready),       64'd1);
    chk("async stall",   64'(bus.arb_o_pipe_stall), 64'd0);
    chk("async rd",      64'(bus.arb_o_rd),         64'd0);
`ifdef WB_ARB_PERF_EN
    chk("async stall_cnt", 64'(bus.arb_o_stall_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst pending", 64'(bus.arb_o_pending), 64'd0);
    chk("post-rst wen",     64'(bus.arb_o_wen),     64'd0);

    // Randomized traffic against the reference model
    model_reset();
    held = 1'b0;
    pw = 1'b0; prd = '0; pd = '0;
    for (int c = 0; c < 800; c++) begin
      if (!held) begin
        pw  = ($urandom_range(0, 9) < 7);
        prd = 5'($urandom_range(0, 7));
        pd  = {$urandom, $urandom};
      end
      lv  = ($urandom_range(0, 9) < 4);
      lrd = 5'($urandom_range(0, 7));
      ld  = {$urandom, $urandom};
      drive(pw, prd, pd, lv, lrd, ld);
      #2;
      m_stl = (mq.size() > 0) && (m_starve == STARVE_MAX);
      chk($sformatf("r%0d ready", c),   64'(bus.lu_o_ready),       64'(mq.size() < DEPTH));
      chk($sformatf("r%0d stall", c),   64'(bus.arb_o_pipe_stall), 64'(m_stl));
      chk($sformatf("r%0d pending", c), 64'(bus.arb_o_pending),    64'(mq.size() > 0));
      held = m_stl && pw;
      @(posedge clk);
      model_step(pw, prd, pd, lv, lrd, ld);
      #1;
      chk($sformatf("r%0d wen", c),  64'(bus.arb_o_wen), 64'(m_wen));
      chk($sformatf("r%0d rd", c),   64'(bus.arb_o_rd),  64'(m_rd));
      chk($sformatf("r%0d data", c), bus.arb_o_data,     m_data);
    end
`ifdef WB_ARB_PERF_EN
    chk("rnd stall_cnt",  64'(bus.arb_o_stall_cnt),  64'(m_stalls));
    chk("rnd squash_cnt", 64'(bus.arb_o_squash_cnt), 64'(m_squashes));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
